// File: rtl/vga_timing_ctrl_if.sv
// Pixel stream and display bundle for the raster timing controller.
// The master side is the timing controller: it consumes pixels from the
// line buffer and drives the sync/blank/colour lines toward the display.
interface vga_timing_ctrl_if;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_rd;
  logic        hsync;
  logic        vsync;
  logic        csync;
  logic        blank;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic        underflow;

  modport master (
    input  pix_valid, pix_data,
    output pix_rd, hsync, vsync, csync, blank, red, green, blue,
           frame_start, underflow
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_rd, hsync, vsync, csync, blank, red, green, blue,
           frame_start, underflow
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Programmable raster timing controller. Horizontal and vertical FSMs walk
// sync/back-porch/active/front-porch intervals whose lengths are sampled into
// shadow registers once per frame. Pixels are popped from the line buffer
// during active video and every display output is registered on clk_p.
module vga_timing_ctrl #(
  parameter int HW = 12,
  parameter int VW = 12
) (
  input  logic          clk_p,
  input  logic          rst_i,
  input  logic          en,
  input  logic [HW-1:0] h_sync_len,
  input  logic [HW-1:0] h_bp_len,
  input  logic [HW-1:0] h_act_len,
  input  logic [HW-1:0] h_fp_len,
  input  logic [VW-1:0] v_sync_len,
  input  logic [VW-1:0] v_bp_len,
  input  logic [VW-1:0] v_act_len,
  input  logic [VW-1:0] v_fp_len,
  input  logic          hpol,
  input  logic          vpol,
  input  logic          cpol,
  input  logic          bpol,
  vga_timing_ctrl_if.master vif
);

  typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} hstate_t;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} vstate_t;

  hstate_t       hstate;
  vstate_t       vstate;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // running is low on the first enabled cycle after reset or en rising;
  // that cycle uses the live length inputs while the shadows are loaded.
  logic          running;

  logic [HW-1:0] sh_h_sync, sh_h_bp, sh_h_act, sh_h_fp;
  logic [VW-1:0] sh_v_sync, sh_v_bp, sh_v_act, sh_v_fp;

  logic [HW-1:0] h_len;
  logic [VW-1:0] v_len;
  logic          line_end;
  logic          frame_end;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;

  // Length of the interval currently being timed, horizontal and vertical
  always_comb begin
    h_len = '0;
    v_len = '0;
    case (hstate)
      H_SYNC: h_len = running ? sh_h_sync : h_sync_len;
      H_BP:   h_len = running ? sh_h_bp   : h_bp_len;
      H_ACT:  h_len = running ? sh_h_act  : h_act_len;
      H_FP:   h_len = running ? sh_h_fp   : h_fp_len;
      default: h_len = '0;
    endcase
    case (vstate)
      V_SYNC: v_len = running ? sh_v_sync : v_sync_len;
      V_BP:   v_len = running ? sh_v_bp   : v_bp_len;
      V_ACT:  v_len = running ? sh_v_act  : v_act_len;
      V_FP:   v_len = running ? sh_v_fp   : v_fp_len;
      default: v_len = '0;
    endcase
  end

  assign line_end  = (hstate == H_FP) && (hcnt == h_len);
  assign frame_end = line_end && (vstate == V_FP) && (vcnt == v_len);
  assign active    = (hstate == H_ACT) && (vstate == V_ACT);
  assign hs_raw    = en && (hstate == H_SYNC);
  assign vs_raw    = en && (vstate == V_SYNC);

  assign vif.pix_rd = en && active && vif.pix_valid;

  // Horizontal and vertical interval sequencing; en low parks at frame origin
  always_ff @(posedge clk_p or posedge rst_i) begin
    if (rst_i) begin
      hstate  <= H_SYNC;
      vstate  <= V_SYNC;
      hcnt    <= '0;
      vcnt    <= '0;
      running <= 1'b0;
    end else if (!en) begin
      hstate  <= H_SYNC;
      vstate  <= V_SYNC;
      hcnt    <= '0;
      vcnt    <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (hcnt == h_len) begin
        hcnt <= '0;
        case (hstate)
          H_SYNC:  hstate <= H_BP;
          H_BP:    hstate <= H_ACT;
          H_ACT:   hstate <= H_FP;
          default: hstate <= H_SYNC;
        endcase
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (line_end) begin
        if (vcnt == v_len) begin
          vcnt <= '0;
          case (vstate)
            V_SYNC:  vstate <= V_BP;
            V_BP:    vstate <= V_ACT;
            V_ACT:   vstate <= V_FP;
            default: vstate <= V_SYNC;
          endcase
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end
    end
  end

  // Capture interval lengths at start-up and at each frame boundary
  always_ff @(posedge clk_p or posedge rst_i) begin
    if (rst_i) begin
      sh_h_sync <= '0;
      sh_h_bp   <= '0;
      sh_h_act  <= '0;
      sh_h_fp   <= '0;
      sh_v_sync <= '0;
      sh_v_bp   <= '0;
      sh_v_act  <= '0;
      sh_v_fp   <= '0;
    end else if (en && (!running || frame_end)) begin
      sh_h_sync <= h_sync_len;
      sh_h_bp   <= h_bp_len;
      sh_h_act  <= h_act_len;
      sh_h_fp   <= h_fp_len;
      sh_v_sync <= v_sync_len;
      sh_v_bp   <= v_bp_len;
      sh_v_act  <= v_act_len;
      sh_v_fp   <= v_fp_len;
    end
  end

  // Register display outputs one clock behind the state that produced them
  always_ff @(posedge clk_p or posedge rst_i) begin
    if (rst_i) begin
      vif.hsync       <= 1'b0;
      vif.vsync       <= 1'b0;
      vif.csync       <= 1'b0;
      vif.blank       <= 1'b1;
      vif.red         <= '0;
      vif.green       <= '0;
      vif.blue        <= '0;
      vif.frame_start <= 1'b0;
      vif.underflow   <= 1'b0;
    end else begin
      vif.hsync <= hs_raw ^ hpol;
      vif.vsync <= vs_raw ^ vpol;
      vif.csync <= (hs_raw | vs_raw) ^ cpol;
      vif.blank <= !(en && active) ^ bpol;
      if (en && active && vif.pix_valid) begin
        {vif.red, vif.green, vif.blue} <= vif.pix_data;
      end else begin
        {vif.red, vif.green, vif.blue} <= '0;
      end
      vif.underflow   <= en && active && !vif.pix_valid;
      vif.frame_start <= en && (hstate == H_SYNC) && (hcnt == '0) &&
                         (vstate == V_SYNC) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. A small raster model derived from the
// programmed interval lengths predicts every output cycle by cycle, and a few
// hand-picked cycles are also checked against literal values.
module tb_vga_timing_ctrl;
  localparam int HW = 12;
  localparam int VW = 12;

  logic          clk_p = 1'b0;
  logic          rst_i = 1'b1;
  logic          en = 1'b1;
  logic [HW-1:0] h_sync_len, h_bp_len, h_act_len, h_fp_len;
  logic [VW-1:0] v_sync_len, v_bp_len, v_act_len, v_fp_len;
  logic          hpol, vpol, cpol, bpol;

  vga_timing_ctrl_if vif ();

  vga_timing_ctrl #(.HW(HW), .VW(VW)) dut (
    .clk_p      (clk_p),
    .rst_i      (rst_i),
    .en         (en),
    .h_sync_len (h_sync_len),
    .h_bp_len   (h_bp_len),
    .h_act_len  (h_act_len),
    .h_fp_len   (h_fp_len),
    .v_sync_len (v_sync_len),
    .v_bp_len   (v_bp_len),
    .v_act_len  (v_act_len),
    .v_fp_len   (v_fp_len),
    .hpol       (hpol),
    .vpol       (vpol),
    .cpol       (cpol),
    .bpol       (bpol),
    .vif        (vif)
  );

  always #5 clk_p = ~clk_p;

  int   vectors = 0;
  int   miscompares = 0;
  int   hA[4];
  int   hB[4];
  int   vL[4];
  int   t = 0;
  int   drop_t = -1;
  int   change_t = -1;
  logic prev_valid = 1'b1;

  function automatic int sum4(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  // Raster position of cycle s: frame 0 uses hA, later frames use hB
  function automatic void model(input int s, output bit hs, output bit vs,
                                output bit act, output bit fs, output int pix);
    int h[4];
    int vfl, ll, f0, f, line, p, hst, vst;
    vfl = sum4(vL) + 4;
    f0  = (sum4(hA) + 4) * vfl;
    if (s < f0) begin
      h = hA;
      f = s;
    end else begin
      h = hB;
      f = (s - f0) % ((sum4(hB) + 4) * vfl);
    end
    ll   = sum4(h) + 4;
    line = f / ll;
    p    = f % ll;
    hst  = h[0] + h[1] + 2;
    vst  = vL[0] + vL[1] + 2;
    hs   = (p <= h[0]);
    vs   = (line <= vL[0]);
    act  = (p >= hst) && (p <= hst + h[2]) && (line >= vst) && (line <= vst + vL[2]);
    fs   = (f == 0);
    pix  = act ? ((line - vst) * (h[2] + 1) + (p - hst) + 1) : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_hsync"}, 32'(vif.hsync), 32'd0);
    checkOutput({tag, "_vsync"}, 32'(vif.vsync), 32'd0);
    checkOutput({tag, "_csync"}, 32'(vif.csync), 32'd0);
    checkOutput({tag, "_blank"}, 32'(vif.blank), 32'd1);
    checkOutput({tag, "_rgb"}, 32'({vif.red, vif.green, vif.blue}), 32'd0);
    checkOutput({tag, "_fstart"}, 32'(vif.frame_start), 32'd0);
    checkOutput({tag, "_uflow"}, 32'(vif.underflow), 32'd0);
  endtask

  task automatic assertReset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_p);
    #1;
  endtask

  task automatic releaseReset();
    @(posedge clk_p);
    #1;
    rst_i = 1'b0;
    t = 0;
    prev_valid = 1'b1;
  endtask

  // Drive n cycles of line-buffer traffic and check every output each cycle
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      bit   hs, vs, act, fs, phs, pvs, pact, pfs;
      int   pix, ppix;
      logic valid;
      model(t, hs, vs, act, fs, pix);
      valid = (t != drop_t);
      if (t == change_t) h_act_len = 12'(hB[2]);
      vif.pix_valid = valid;
      vif.pix_data  = 24'(pix);
      #1;
      checkOutput("pix_rd", 32'(vif.pix_rd), 32'(act && valid));
      if (t == 0) begin
        checkReset("first");
      end else begin
        model(t - 1, phs, pvs, pact, pfs, ppix);
        checkOutput("hsync", 32'(vif.hsync), 32'(phs ^ hpol));
        checkOutput("vsync", 32'(vif.vsync), 32'(pvs ^ vpol));
        checkOutput("csync", 32'(vif.csync), 32'((phs | pvs) ^ cpol));
        checkOutput("blank", 32'(vif.blank), 32'(!pact ^ bpol));
        checkOutput("rgb", 32'({vif.red, vif.green, vif.blue}),
                    (pact && prev_valid) ? 32'(ppix) : 32'd0);
        checkOutput("underflow", 32'(vif.underflow), 32'(pact && !prev_valid));
        checkOutput("frame_start", 32'(vif.frame_start), 32'(pfs));
      end
      prev_valid = valid;
      @(posedge clk_p);
      #1;
      t++;
    end
  endtask

  initial begin
    hA = '{1, 1, 3, 0};
    hB = '{1, 1, 3, 0};
    vL = '{0, 0, 1, 0};
    h_sync_len = 12'd1;  h_bp_len = 12'd1;  h_act_len = 12'd3;  h_fp_len = 12'd0;
    v_sync_len = 12'd0;  v_bp_len = 12'd0;  v_act_len = 12'd1;  v_fp_len = 12'd0;
    hpol = 1'b0;  vpol = 1'b0;  cpol = 1'b0;  bpol = 1'b0;
    vif.pix_valid = 1'b1;
    vif.pix_data  = 24'h0;
    repeat (3) @(posedge clk_p);
    #1;

    $display("[TB] reset state");
    checkReset("rst");

    $display("[TB] basic timing with incrementing pixels");
    releaseReset();
    applyStimulus(1);
    checkOutput("fs_t1", 32'(vif.frame_start), 32'd1);
    checkOutput("hs_t1", 32'(vif.hsync), 32'd1);
    applyStimulus(22);
    checkOutput("rgb_first", 32'({vif.red, vif.green, vif.blue}), 32'h000001);
    checkOutput("blank_first", 32'(vif.blank), 32'd0);
    applyStimulus(12);
    checkOutput("rgb_last", 32'({vif.red, vif.green, vif.blue}), 32'h000008);
    applyStimulus(11);
    checkOutput("fs_t46", 32'(vif.frame_start), 32'd1);
    applyStimulus(49);

    $display("[TB] inverted polarities");
    assertReset();
    hpol = 1'b1;  vpol = 1'b1;  cpol = 1'b1;  bpol = 1'b1;
    #1;
    checkReset("rst_pol");
    releaseReset();
    applyStimulus(1);
    checkOutput("pol_hs_t1", 32'(vif.hsync), 32'd0);
    checkOutput("pol_cs_t1", 32'(vif.csync), 32'd0);
    checkOutput("pol_bl_t1", 32'(vif.blank), 32'd0);
    applyStimulus(50);

    $display("[TB] line buffer underflow");
    assertReset();
    hpol = 1'b0;  vpol = 1'b0;  cpol = 1'b0;  bpol = 1'b0;
    drop_t = 23;
    releaseReset();
    applyStimulus(24);
    checkOutput("uf_pulse", 32'(vif.underflow), 32'd1);
    checkOutput("uf_rgb", 32'({vif.red, vif.green, vif.blue}), 32'd0);
    checkOutput("uf_blank", 32'(vif.blank), 32'd0);
    applyStimulus(1);
    checkOutput("uf_next_rgb", 32'({vif.red, vif.green, vif.blue}), 32'h000003);
    applyStimulus(30);
    drop_t = -1;

    $display("[TB] mid-frame active length change");
    assertReset();
    releaseReset();
    hB[2] = 1;
    change_t = 10;
    applyStimulus(80);
    checkOutput("chg_fs_80", 32'(vif.frame_start), 32'd0);
    applyStimulus(1);
    checkOutput("chg_fs_81", 32'(vif.frame_start), 32'd1);
    applyStimulus(40);
    change_t = -1;
    hB[2] = 3;
    h_act_len = 12'd3;

    $display("[TB] reset during active video");
    assertReset();
    releaseReset();
    applyStimulus(22);
    vif.pix_valid = 1'b1;
    vif.pix_data  = 24'h000001;
    #1;
    checkOutput("pre_rst_pix_rd", 32'(vif.pix_rd), 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_pix_rd", 32'(vif.pix_rd), 32'd0);
    checkReset("mid_rst");
    releaseReset();
    applyStimulus(1);
    checkOutput("rerun_fs", 32'(vif.frame_start), 32'd1);
    applyStimulus(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Programmable raster timing controller that drives the VGA display interface (pixel clock, hsync, vsync, csync, blank, red/green/blue). It sequences horizontal and vertical sync/porch/active intervals, pops pixels from an upstream line buffer during active video, and registers all display outputs in the pixel clock domain. It sits between the video line FIFO and the display interface's output clocking block.

## Interface
- HW, 12, width of horizontal timing fields and horizontal counter
- VW, 12, width of vertical timing fields and vertical counter
- clk_p  in  1  pixel clock; all logic on posedge
- rst_i  in  1  asynchronous, active-high reset
- en  in  1  timing enable; 0 holds the controller in reset state
- h_sync_len, h_bp_len, h_act_len, h_fp_len  in  HW each  horizontal interval lengths minus 1, in pixel clocks
- v_sync_len, v_bp_len, v_act_len, v_fp_len  in  VW each  vertical interval lengths minus 1, in lines
- hpol, vpol, cpol, bpol  in  1 each  output polarity; 0 = active-high, 1 = inverted
- pix_valid  in  1  line buffer has a pixel available
- pix_data  in  24  {red, green, blue} at head of line buffer
- pix_rd  out  1  pop strobe to line buffer
- hsync, vsync, csync, blank  out  1 each  display sync/blank
- red, green, blue  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse aligned with first output cycle of a frame
- underflow  out  1  one-cycle pulse: active pixel needed, pix_valid low

## Operation
- Horizontal FSM: H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC. Counter hcnt counts 0..len within each state; at hcnt==len, advance and clear hcnt. Each state lasts len+1 clocks; len 0 = 1 clock.
- Vertical FSM: V_SYNC -> V_BP -> V_ACT -> V_FP -> V_SYNC, advances only on the last clock of H_FP (line end); vcnt counts lines 0..len per state.
- Shadow registers: all eight length inputs captured on reset-release/en rise and at each frame end (last clock of H_FP in last line of V_FP). Mid-frame input changes take effect at next frame.
- active = (hstate==H_ACT) && (vstate==V_ACT) (from current registered state).
- pix_rd = en && active && pix_valid (combinational).
- Raw levels: hs = hstate==H_SYNC; vs = vstate==V_SYNC; cs = hs | vs; bl = !active.
- Registered outputs: hsync=hs^hpol, vsync=vs^vpol, csync=cs^cpol, blank=bl^bpol; RGB = pix_data if active && pix_valid, else 0.
- underflow registered: active && !pix_valid. Pixel is not re-requested; the slot shows black.
- frame_start registered: hstate==H_SYNC, hcnt==0, vstate==V_SYNC, vcnt==0, en=1.
- en=0: FSMs/counters forced to H_SYNC/V_SYNC, counts 0; outputs driven to inactive values (below); pix_rd=0.

## Timing
- Reset (rst_i high, async): hstate=H_SYNC, vstate=V_SYNC, counts 0, shadows 0; hsync=vsync=csync=0, blank=1, RGB=0, frame_start=0, underflow=0. Polarity inputs not applied during reset.
- First cycle after rst_i deasserts with en=1: state H_SYNC/V_SYNC count 0 -> frame_start and hsync/vsync high one cycle later.
- Latency: all outputs 1 clock after the state that produced them; pix_rd in cycle N -> RGB shows that pixel in cycle N+1, aligned with blank deasserted.
- Line period = sum(h_*_len)+4 clocks; frame = (sum(v_*_len)+4) lines.
- Reset mid-frame: immediate return to reset state; no partial pix_rd after assertion.
- en falling mid-line: next clock state reset; outputs inactive the clock after.
- Counters never exceed len; wrap only via state advance.

## Test plan
- h lens {1,1,3,0}, v lens {0,0,1,0}, polarities 0, pix_valid=1 -> line 9 clocks (hsync 2, blank low 4), frame 45 clocks, frame_start every 45 clocks, 8 pix_rd per frame.
- Same timing, pix_data incrementing from 0x000001 -> RGB sequence 1..8 per frame, each one cycle after its pix_rd, blank=0 exactly those cycles.
- pix_valid forced 0 for 2nd active pixel of line 1 -> underflow pulse that cycle+1, RGB=0 in that slot, no pix_rd, following pixels unaffected.
- hpol=vpol=cpol=bpol=1 -> all four outputs inverted versus scenario 1; reset values still 0/0/0/1.
- Change h_act_len 3->1 mid-frame -> current frame keeps 4-pixel lines; next frame lines 7 clocks.
- Assert rst_i during H_ACT of line 2 -> outputs immediately at reset values, pix_rd 0; after release, frame_start 1 clock later and full frame repeats.
